multicycle_cpu: RTL

Parametrised multi-cycle RV32I-subset core, the successor to the single-cycle ALU-only CPU. Each instruction is sequenced through a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine with registered intermediate values. It adds load/store to an internal data memory, SRA/SLTU/immediate-compare operations, a zero-hardwired x0, and halt-on-illegal behaviour. The instruction ROM is loaded through an input array, and all architectural state is exposed on check ports for the bench.

---
 rtl/multicycle_cpu_if.sv | 27 ++
 rtl/multicycle_cpu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if: ROM load port and architectural check ports of the
// multi-cycle RV32I-subset core. The core connects through the slave modport;
// the environment that loads the ROM and observes state uses master.
interface multicycle_cpu_if #(
    parameter int IMEM_DEPTH = 32
);
    logic [31:0] initial_instructions [0:IMEM_DEPTH-1];
    logic [31:0] pc_out_check;
    logic [31:0] instruction_check;
    logic [2:0]  state_check;
    logic [31:0] alu_result_check;
    logic        halted;
    logic [31:0] retired_count;
    logic [31:0] register_check [0:31];

    modport master (
        output initial_instructions,
        input  pc_out_check, instruction_check, state_check, alu_result_check,
        input  halted, retired_count, register_check
    );

    modport slave (
        input  initial_instructions,
        output pc_out_check, instruction_check, state_check, alu_result_check,
        output halted, retired_count, register_check
    );
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle RV32I-subset core (R/I ALU ops, LW, SW) sequenced
// FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK], halting on any illegal
// encoding. Optional build macro MULTICYCLE_CPU_BRANCH_EN adds BEQ/BNE; without
// it opcode 1100011 is illegal and no comparator or target adder exists.
module multicycle_cpu #(
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 32
) (
    input logic              clk,
    input logic              reset,
    multicycle_cpu_if.slave  bus
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
        S_MEM = 3'd3, S_WRITEBACK = 3'd4, S_HALT = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [31:0]        pc, ir, retired;
    logic signed [31:0] a_reg, b_reg, imm_reg, alu_out, mdr;
    logic [31:0]        regs [0:31];
    logic [31:0]        dmem [0:DMEM_DEPTH-1];

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic       is_r, is_i, is_lw, is_sw, is_br, legal, retire, alt;
    logic signed [31:0] imm_dec;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    // ALU shared by R-type and I-type; alt selects SUB or arithmetic shift
    function automatic logic signed [31:0] alu_op(input logic [2:0] f3, input logic sel_alt,
                                                  input logic signed [31:0] x,
                                                  input logic signed [31:0] y);
        case (f3)
            3'b000:  return sel_alt ? x - y : x + y;
            3'b001:  return x << y[4:0];
            3'b010:  return {31'b0, x < y};
            3'b011:  return {31'b0, $unsigned(x) < $unsigned(y)};
            3'b100:  return x ^ y;
            3'b101:  return sel_alt ? x >>> y[4:0] : $signed($unsigned(x) >> y[4:0]);
            3'b110:  return x | y;
            default: return x & y;
        endcase
    endfunction

    // Instruction class, legality and immediate selection from IR
    always_comb begin
        is_r = 1'b0; is_i = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_br = 1'b0;
        imm_dec = {{20{ir[31]}}, ir[31:20]};
        case (opcode)
            OP_R:  is_r = (funct7 == 7'b0000000) ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            OP_I:  is_i = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                          (funct3 == 3'b101) ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) :
                          1'b1;
            OP_LW: is_lw = (funct3 == 3'b010);
            OP_SW: begin
                is_sw   = (funct3 == 3'b010);
                imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
`ifdef MULTICYCLE_CPU_BRANCH_EN
            OP_BR: begin
                is_br   = (funct3 == 3'b000 || funct3 == 3'b001);
                imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
`endif
            default: ;
        endcase
        legal  = is_r | is_i | is_lw | is_sw | is_br;
        alt    = is_r ? ir[30] : (funct3 == 3'b101 && ir[30]);
        retire = (state == S_EXECUTE && is_br) || (state == S_MEM && is_sw) ||
                 (state == S_WRITEBACK);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state sequencing per instruction class
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     state_next = S_DECODE;
            S_DECODE:    state_next = legal ? S_EXECUTE : S_HALT;
            S_EXECUTE:   state_next = (is_lw || is_sw) ? S_MEM :
                                      is_br ? S_FETCH : S_WRITEBACK;
            S_MEM:       state_next = is_lw ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: state_next = S_FETCH;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_FETCH;
        endcase
    end

    // Datapath registers, PC and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0; ir <= '0; retired <= '0;
            a_reg <= '0; b_reg <= '0; imm_reg <= '0; alu_out <= '0; mdr <= '0;
        end else begin
            case (state)
                S_FETCH:  ir <= bus.initial_instructions[pc[IW+1:2]];
                S_DECODE: begin
                    a_reg   <= $signed(regs[rs1]);
                    b_reg   <= $signed(regs[rs2]);
                    imm_reg <= imm_dec;
                end
                S_EXECUTE: begin
                    if (is_lw || is_sw) alu_out <= a_reg + imm_reg;
                    else                alu_out <= alu_op(funct3, alt, a_reg, is_r ? b_reg : imm_reg);
`ifdef MULTICYCLE_CPU_BRANCH_EN
                    if (is_br)
                        pc <= ((funct3[0] ? (a_reg != b_reg) : (a_reg == b_reg)))
                              ? pc + $unsigned(imm_reg) : pc + 32'd4;
`endif
                end
                S_MEM:    if (is_lw) mdr <= $signed(dmem[alu_out[DW+1:2]]);
                default:  ;
            endcase
            if (retire && !is_br) pc <= pc + 32'd4;
            if (retire) retired <= retired + 32'd1;
        end
    end

    // Register file: x0 never written so it always reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (state == S_WRITEBACK && rd != 5'd0) begin
            regs[rd] <= is_lw ? mdr : alu_out;
        end
    end

    // Data memory: word-indexed, byte offset ignored, index wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else if (state == S_MEM && is_sw) begin
            dmem[alu_out[DW+1:2]] <= b_reg;
        end
    end

    assign bus.pc_out_check      = pc;
    assign bus.instruction_check = ir;
    assign bus.state_check       = state;
    assign bus.alu_result_check  = alu_out;
    assign bus.halted            = (state == S_HALT);
    assign bus.retired_count     = retired;
    assign bus.register_check    = regs;
endmodule
